// File: rtl/scale_nn_sel_pkg.sv
// Shared constants, coordinate type and step clamp for the nearest-neighbour
// down-scaling selector.
package scale_pkg;
  localparam int          FRAC_W   = 16;
  localparam int          COORD_W  = 16;
  localparam logic [31:0] STEP_ONE = 32'h0001_0000;

  // Coordinate half of a FIFO entry; the pixel field is added by the top,
  // since its width follows the DW parameter.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } xy_t;

  // Steps below 1.0 would upscale; force them to 1:1.
  function automatic logic [31:0] clamp_step(input logic [31:0] s);
    return (s < STEP_ONE) ? STEP_ONE : s;
  endfunction
endpackage

// File: rtl/scale_nn_sel_sync_fifo.sv
// First-word fall-through synchronous FIFO with synchronous flush and count outputs.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic [AW:0]      count_next
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr, r_rd;
  logic [AW:0]                 r_count;
  logic                        w_push, w_pop;

  // Flush wins over any same-cycle push or pop.
  assign w_push = push && !flush && (r_count != FULL);
  assign w_pop  = pop && !flush && (r_count != '0);

  always_comb begin
    count_next = r_count;
    if (flush)
      count_next = '0;
    else if (w_push && !w_pop)
      count_next = r_count + (AW+1)'(1);
    else if (!w_push && w_pop)
      count_next = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_count <= count_next;
      if (flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr] <= din;
          r_wr        <= r_wr + AW'(1);
        end
        if (w_pop)
          r_rd <= r_rd + AW'(1);
      end
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;
endmodule

// File: rtl/scale_nn_sel.sv
// Nearest-neighbour down-scaling selector: Q16.16 step accumulators pick source
// pixels onto the output grid and queue them in a FWFT FIFO for the writer.
module scale_nn_sel
  import scale_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = 16
) (
  input  logic               vin_clk,
  input  logic               rst_n,
  input  logic               frame_sync_n,
  input  logic               wr_valid,
  input  logic [COORD_W-1:0] vin_wr_x,
  input  logic [COORD_W-1:0] vin_wr_y,
  input  logic [DW-1:0]      vin_wr_dat,
  input  logic [COORD_W-1:0] vin_xres,
  input  logic [COORD_W-1:0] vin_yres,
  input  logic [COORD_W-1:0] vout_xres,
  input  logic [COORD_W-1:0] vout_yres,
  input  logic [31:0]        step_x,
  input  logic [31:0]        step_y,
  output logic               vout_ready,
  output logic               sc_valid,
  input  logic               sc_ready,
  output logic [COORD_W-1:0] sc_x,
  output logic [COORD_W-1:0] sc_y,
  output logic [DW-1:0]      sc_dat,
  output logic               frame_done
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    xy_t           xy;
    logic [DW-1:0] dat;
  } entry_t;

  logic [31:0]        r_acc_x, r_acc_y;
  logic [COORD_W-1:0] r_out_x, r_out_y;
  logic               r_vout_ready, r_frame_done;

  logic [31:0] w_step_x, w_step_y;
  logic        w_row_sel, w_pick, w_eol, w_last, w_pop;
  entry_t      w_din, w_head;
  logic [AW:0] w_count, w_cnt_next;

  assign w_step_x = clamp_step(step_x);
  assign w_step_y = clamp_step(step_y);

  assign w_row_sel = (vin_wr_y == r_acc_y[31:FRAC_W]) && (r_out_y < vout_yres)
                   && (vin_wr_y < vin_yres);
  assign w_pick    = wr_valid && w_row_sel && (vin_wr_x == r_acc_x[31:FRAC_W])
                   && (r_out_x < vout_xres);
  assign w_eol     = wr_valid && (vin_wr_x == vin_xres - 16'd1);
  assign w_last    = (r_out_x == vout_xres - 16'd1) && (r_out_y == vout_yres - 16'd1);

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_x      <= '0;
      r_acc_y      <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_frame_done <= 1'b0;
    end else if (!frame_sync_n) begin
      r_acc_x      <= '0;
      r_acc_y      <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pick && w_last;
      // Row end overrides the x advance of a same-cycle pick; the pick is
      // still pushed into the FIFO below.
      if (w_eol) begin
        r_acc_x <= '0;
        r_out_x <= '0;
        if (w_row_sel) begin
          r_out_y <= r_out_y + 16'd1;
          r_acc_y <= r_acc_y + w_step_y;
        end
      end else if (w_pick) begin
        r_out_x <= r_out_x + 16'd1;
        r_acc_x <= r_acc_x + w_step_x;
      end
    end
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) r_vout_ready <= 1'b0;
    else        r_vout_ready <= (w_cnt_next < DEPTH_C);
  end

  assign w_din.xy.x = r_out_x;
  assign w_din.xy.y = r_out_y;
  assign w_din.dat  = vin_wr_dat;
  assign w_pop      = sc_valid && sc_ready;

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (vin_clk),
    .rst_n      (rst_n),
    .flush      (!frame_sync_n),
    .push       (w_pick),
    .din        (w_din),
    .pop        (w_pop),
    .dout       (w_head),
    .count      (w_count),
    .count_next (w_cnt_next)
  );

  assign sc_valid   = (w_count != '0);
  assign sc_x       = w_head.xy.x;
  assign sc_y       = w_head.xy.y;
  assign sc_dat     = w_head.dat;
  assign vout_ready = r_vout_ready;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_scale_nn_sel.sv
// Directed self-checking bench for scale_nn_sel.
module tb_scale_nn_sel;
  logic        vin_clk = 1'b0;
  logic        rst_n = 1'b1, frame_sync_n = 1'b1, wr_valid = 1'b0, sc_ready = 1'b0;
  logic [15:0] vin_wr_x = '0, vin_wr_y = '0, vin_wr_dat = '0;
  logic [15:0] vin_xres = 16'd4, vin_yres = 16'd1, vout_xres = 16'd4, vout_yres = 16'd1;
  logic [31:0] step_x = 32'h10000, step_y = 32'h10000;
  logic        vout_ready, sc_valid, frame_done;
  logic [15:0] sc_x, sc_y, sc_dat;

  int checks = 0, errors = 0, fd_cnt = 0;

  typedef struct packed { logic [15:0] x, y, d; } ent_t;
  ent_t q[$];

  scale_nn_sel #(.FIFO_DEPTH(16), .DW(16)) dut (
    .vin_clk(vin_clk), .rst_n(rst_n), .frame_sync_n(frame_sync_n), .wr_valid(wr_valid),
    .vin_wr_x(vin_wr_x), .vin_wr_y(vin_wr_y), .vin_wr_dat(vin_wr_dat),
    .vin_xres(vin_xres), .vin_yres(vin_yres), .vout_xres(vout_xres), .vout_yres(vout_yres),
    .step_x(step_x), .step_y(step_y), .vout_ready(vout_ready), .sc_valid(sc_valid),
    .sc_ready(sc_ready), .sc_x(sc_x), .sc_y(sc_y), .sc_dat(sc_dat), .frame_done(frame_done)
  );

  always #5 vin_clk = ~vin_clk;

  // Record every handshake and frame_done pulse, sampled mid-low-phase.
  always begin
    @(negedge vin_clk);
    #1;
    if (rst_n && sc_valid && sc_ready) q.push_back({sc_x, sc_y, sc_dat});
    if (frame_done) fd_cnt++;
  end

  function automatic logic [15:0] pdat(input int x, input int y);
    return 16'(32'h5000 + y * 256 + x);
  endfunction

  task automatic drive_px(input int x, input int y);
    int t = 0;
    while (!vout_ready && t < 200) begin @(negedge vin_clk); t++; end
    if (!vout_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout px(%0d,%0d): vout_ready=%b required 1", x, y, vout_ready);
    end
    wr_valid = 1'b1; vin_wr_x = 16'(x); vin_wr_y = 16'(y); vin_wr_dat = pdat(x, y);
    @(negedge vin_clk);
    wr_valid = 1'b0;
  endtask

  task automatic feed(input int xr, input int yr);
    for (int y = 0; y < yr; y++)
      for (int x = 0; x < xr; x++) drive_px(x, y);
  endtask

  task automatic drain();
    int t = 0;
    while (sc_valid && t < 200) begin @(negedge vin_clk); t++; end
    if (sc_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: sc_valid=%b required 0", sc_valid);
    end
    repeat (3) @(negedge vin_clk);
  endtask

  task automatic setup(input int ixr, input int iyr, input int oxr, input int oyr,
                       input logic [31:0] sx, input logic [31:0] sy);
    vin_xres = 16'(ixr); vin_yres = 16'(iyr); vout_xres = 16'(oxr); vout_yres = 16'(oyr);
    step_x = sx; step_y = sy;
    @(negedge vin_clk); frame_sync_n = 1'b0;
    @(negedge vin_clk); frame_sync_n = 1'b1;
    q.delete(); fd_cnt = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vout_ready !== 1'b0 || sc_valid !== 1'b0 || sc_x !== 16'd0 || sc_y !== 16'd0
        || sc_dat !== 16'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b x=%h y=%h d=%h fd=%b required all 0",
               vout_ready, sc_valid, sc_x, sc_y, sc_dat, frame_done);
    end
    @(negedge vin_clk); rst_n = 1'b1;
    #1;
    checks++;
    if (vout_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b required 0", vout_ready);
    end
    @(negedge vin_clk);
    checks++;
    if (vout_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release: got %b required 1", vout_ready);
    end
  endtask

  task automatic test_2x();
    int sx[4] = '{0, 2, 4, 6};
    int k;
    setup(8, 4, 4, 2, 32'h20000, 32'h20000);
    sc_ready = 1'b1;
    feed(8, 4);
    drain();
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL 2x_count: got %0d required 8", q.size());
    end
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 4; ox++) begin
        k = oy * 4 + ox;
        if (k < q.size()) begin
          checks++;
          if (q[k] !== {16'(ox), 16'(oy), pdat(sx[ox], 2 * oy)}) begin
            errors++;
            $display("FAIL 2x_entry%0d: got %h required %h", k, q[k],
                     {16'(ox), 16'(oy), pdat(sx[ox], 2 * oy)});
          end
        end
      end
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL 2x_frame_done: got %0d pulses required 1", fd_cnt);
    end
  endtask

  task automatic test_frac();
    int sx[4] = '{0, 1, 3, 4};
    setup(6, 1, 4, 1, 32'h18000, 32'h10000);
    sc_ready = 1'b1;
    feed(6, 1);
    drain();
    checks++;
    if (q.size() != 4) begin
      errors++; $display("FAIL frac_count: got %0d required 4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      checks++;
      if (q[i] !== {16'(i), 16'd0, pdat(sx[i], 0)}) begin
        errors++;
        $display("FAIL frac_entry%0d: got %h required %h", i, q[i], {16'(i), 16'd0, pdat(sx[i], 0)});
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL frac_frame_done: got %0d required 1", fd_cnt);
    end
  endtask

  task automatic test_clamp();
    setup(4, 1, 4, 1, 32'h08000, 32'h10000);
    sc_ready = 1'b1;
    feed(4, 1);
    drain();
    checks++;
    if (q.size() != 4) begin
      errors++; $display("FAIL clamp_count: got %0d required 4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      checks++;
      if (q[i] !== {16'(i), 16'd0, pdat(i, 0)}) begin
        errors++;
        $display("FAIL clamp_entry%0d: got %h required %h", i, q[i], {16'(i), 16'd0, pdat(i, 0)});
      end
    end
  endtask

  task automatic test_backpressure();
    setup(32, 1, 32, 1, 32'h10000, 32'h10000);
    sc_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_px(i, 0);
    checks++;
    if (vout_ready !== 1'b0 || sc_valid !== 1'b1 || sc_x !== 16'd0) begin
      errors++;
      $display("FAIL bp_full: rdy=%b vld=%b x=%0d required 0 1 0", vout_ready, sc_valid, sc_x);
    end
    @(negedge vin_clk);
    checks++;
    if (sc_x !== 16'd0 || sc_dat !== pdat(0, 0) || vout_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: x=%0d d=%h rdy=%b required 0 %h 0", sc_x, sc_dat, vout_ready, pdat(0, 0));
    end
    sc_ready = 1'b1;
    @(negedge vin_clk);
    checks++;
    if (vout_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_rise: got %b required 1", vout_ready);
    end
    for (int i = 16; i < 32; i++) drive_px(i, 0);
    drain();
    checks++;
    if (q.size() != 32) begin
      errors++; $display("FAIL bp_count: got %0d required 32", q.size());
    end
    for (int i = 0; i < 32 && i < q.size(); i++) begin
      checks++;
      if (q[i] !== {16'(i), 16'd0, pdat(i, 0)}) begin
        errors++;
        $display("FAIL bp_entry%0d: got %h required %h", i, q[i], {16'(i), 16'd0, pdat(i, 0)});
      end
    end
  endtask

  task automatic test_restart();
    setup(32, 1, 32, 1, 32'h10000, 32'h10000);
    sc_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_px(i, 0);
    checks++;
    if (sc_valid !== 1'b1) begin
      errors++; $display("FAIL restart_queued: sc_valid=%b required 1", sc_valid);
    end
    frame_sync_n = 1'b0;
    @(negedge vin_clk);
    checks++;
    if (sc_valid !== 1'b0) begin
      errors++; $display("FAIL restart_flush: sc_valid=%b required 0", sc_valid);
    end
    frame_sync_n = 1'b1;
    setup(4, 2, 4, 2, 32'h10000, 32'h10000);
    sc_ready = 1'b1;
    feed(4, 2);
    drain();
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL restart_count: got %0d required 8", q.size());
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      checks++;
      if (q[i] !== {16'(i % 4), 16'(i / 4), pdat(i % 4, i / 4)}) begin
        errors++;
        $display("FAIL restart_entry%0d: got %h required %h", i, q[i],
                 {16'(i % 4), 16'(i / 4), pdat(i % 4, i / 4)});
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL restart_frame_done: got %0d required 1", fd_cnt);
    end
  endtask

  task automatic test_async_reset();
    setup(4, 1, 4, 1, 32'h10000, 32'h10000);
    sc_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_px(i, 0);
    checks++;
    if (sc_valid !== 1'b1 || sc_dat !== pdat(0, 0)) begin
      errors++;
      $display("FAIL areset_pre: vld=%b d=%h required 1 %h", sc_valid, sc_dat, pdat(0, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sc_valid !== 1'b0 || vout_ready !== 1'b0 || sc_dat !== 16'd0 || sc_x !== 16'd0) begin
      errors++;
      $display("FAIL areset_immediate: vld=%b rdy=%b d=%h x=%h required 0 0 0 0",
               sc_valid, vout_ready, sc_dat, sc_x);
    end
    @(negedge vin_clk); rst_n = 1'b1;
    @(negedge vin_clk);
    checks++;
    if (vout_ready !== 1'b1 || sc_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_release: rdy=%b vld=%b required 1 0", vout_ready, sc_valid);
    end
  endtask

  initial begin
    test_reset();
    test_2x();
    test_frac();
    test_clamp();
    test_backpressure();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
